// File: rtl/fp_mul_sched_pkg.sv
// ============================================================================
// Module   : fp_mul_sched_pkg
// Brief    : Shared types and helpers for the FP multiplier scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_mul_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int unsigned C_MANTISSA_SIZE = 23;
    localparam int unsigned C_EXPONENT_SIZE = 8;
    localparam int unsigned C_WORD_W        = C_MANTISSA_SIZE + C_EXPONENT_SIZE + 1;

    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // True when every exponent and mantissa bit is clear; the sign bit is ignored.
    function automatic logic is_zero(input logic [63:0] word, input int unsigned mag_bits);
        logic any_set;
        any_set = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i < mag_bits) any_set = any_set | word[i];
        end
        return !any_set;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin grant starting the search at rr_ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id,
    output logic [NUM_REQ-1:0] grant_onehot
);

    // Walk from the farthest candidate back to rr_ptr so the nearest valid wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            logic [ID_W-1:0] w_idx;
            w_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[w_idx]) begin
                grant_valid = 1'b1;
                grant_id    = w_idx;
            end
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_onehot
        assign grant_onehot[i] = grant_valid && (grant_id == ID_W'(i));
    end

endmodule

`default_nettype wire

// File: rtl/fp_mul_scheduler.sv
// ============================================================================
// Module   : fp_mul_scheduler
// Brief    : Round-robin sharing of one FP multiplier between NUM_REQ ports.
//            Optional zero-operand bypass: FP_MUL_ZERO_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_mul_scheduler
    import fp_mul_sched_pkg::*;
#(
    parameter int Mantissa_Size = 23,
    parameter int Exponent_Size = 8,
    parameter int N             = Mantissa_Size + Exponent_Size,
    parameter int NUM_REQ       = 4,
    parameter int MUL_LATENCY   = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*(N+1)-1:0]        req_a,
    input  logic [NUM_REQ*(N+1)-1:0]        req_b,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [id_width(NUM_REQ)-1:0]    rsp_id,
    output logic [N:0]                      rsp_result,
    output logic                            rsp_overflow,
    output logic                            rsp_zero,
    output logic                            mul_enable,
    output logic                            mul_load,
    output logic [N:0]                      mul_a,
    output logic [N:0]                      mul_b,
    input  logic [N:0]                      mul_result,
    input  logic                            mul_overflow,
    input  logic                            mul_zero
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int W     = N + 1;
    localparam int CNT_W = $clog2(MUL_LATENCY + 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_id;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_result;
    logic               r_overflow;
    logic               r_zero;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_grant_valid;
    logic [ID_W-1:0]    w_grant_id;
    logic [NUM_REQ-1:0] w_grant_onehot;
    logic [ID_W-1:0]    w_next_ptr;
    logic [W-1:0]       w_a_arr [NUM_REQ];
    logic [W-1:0]       w_b_arr [NUM_REQ];
    logic [W-1:0]       w_sel_a;
    logic [W-1:0]       w_sel_b;
    logic               w_bypass;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_a_arr[i] = req_a[i*W +: W];
        assign w_b_arr[i] = req_b[i*W +: W];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arbiter (
        .req_valid    (req_valid),
        .rr_ptr       (r_rr_ptr),
        .grant_valid  (w_grant_valid),
        .grant_id     (w_grant_id),
        .grant_onehot (w_grant_onehot)
    );

    assign w_sel_a    = w_a_arr[w_grant_id];
    assign w_sel_b    = w_b_arr[w_grant_id];
    assign w_next_ptr = (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + ID_W'(1);

`ifdef FP_MUL_ZERO_BYPASS_EN
    assign w_bypass = is_zero(64'(w_sel_a), N) || is_zero(64'(w_sel_b), N);
`else
    assign w_bypass = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        req_ready    = '0;
        mul_enable   = 1'b0;
        mul_load     = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                // Gated by rst so the async-reset window presents no grant.
                if (!rst) req_ready = w_grant_onehot;
                if (w_grant_valid) w_next_state = w_bypass ? RESP : ISSUE;
            end
            ISSUE: begin
                mul_enable   = 1'b1;
                mul_load     = 1'b1;
                w_next_state = WAIT;
            end
            WAIT: begin
                if (r_cnt == CNT_W'(1)) w_next_state = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_id       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_a      <= w_sel_a;
                        r_b      <= w_sel_b;
                        r_id     <= w_grant_id;
                        r_rr_ptr <= w_next_ptr;
                        if (w_bypass) begin
                            r_result   <= '0;
                            r_overflow <= 1'b0;
                            r_zero     <= 1'b1;
                        end
                    end
                end
                ISSUE: r_cnt <= CNT_W'(MUL_LATENCY);
                WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_result   <= mul_result;
                        r_overflow <= mul_overflow;
                        r_zero     <= mul_zero;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mul_a        = r_a;
    assign mul_b        = r_b;
    assign rsp_id       = r_id;
    assign rsp_result   = r_result;
    assign rsp_overflow = r_overflow;
    assign rsp_zero     = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_scheduler.sv
// ============================================================================
// Module   : tb_fp_mul_scheduler
// Brief    : Scoreboard bench for fp_mul_scheduler with a latency-aware multiplier model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_mul_scheduler;
    import fp_mul_sched_pkg::*;

    localparam int NR  = 4;
    localparam int W   = C_WORD_W;
    localparam int LAT = 2;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] res;
        logic        ovf;
        logic        zero;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] req_valid = '0;
    logic [NR-1:0] req_ready;
    logic [NR*W-1:0] req_a = '0;
    logic [NR*W-1:0] req_b = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [1:0]    rsp_id;
    logic [W-1:0]  rsp_result;
    logic          rsp_overflow, rsp_zero;
    logic          mul_enable, mul_load;
    logic [W-1:0]  mul_a, mul_b, mul_result;
    logic          mul_overflow, mul_zero;

    fp_mul_scheduler #(
        .Mantissa_Size (23),
        .Exponent_Size (8),
        .N             (31),
        .NUM_REQ       (NR),
        .MUL_LATENCY   (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero),
        .mul_enable   (mul_enable),
        .mul_load     (mul_load),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_result   (mul_result),
        .mul_overflow (mul_overflow),
        .mul_zero     (mul_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: outputs are garbage until LAT edges after the load strobe.
    int age = 0;
    always @(posedge clk) begin
        if (mul_load) age <= 1;
        else if (age < 1000) age <= age + 1;
    end

    function automatic logic [33:0] model_mul(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3FC00000_40000000: return {2'b00, 32'h40400000};
            64'h40000000_40400000: return {2'b00, 32'h40C00000};
            64'h3F800000_41200000: return {2'b00, 32'h41200000};
            64'h40800000_40800000: return {2'b00, 32'h41800000};
            64'h7F000000_7F000000: return {2'b10, 32'h7F800000};
            64'h00000000_40000000: return {2'b01, 32'h00000000};
            default:               return {2'b11, 32'hBADBAD00};
        endcase
    endfunction

    always_comb begin
        {mul_overflow, mul_zero, mul_result} = {2'b11, 32'hDEADBEEF};
        if (age >= LAT) {mul_overflow, mul_zero, mul_result} = model_mul(mul_a, mul_b);
    end

    int   vectors = 0;
    int   miscompares = 0;
    rsp_t sb[$];
    int   got_ids[$];
    int   acc_cyc = 0, load_cyc = 0, rise_cyc = 0;
    int   load_cnt = 0, en_cnt = 0, bad_ready = 0;
    logic rise_seen = 1'b0, rsp_prev = 1'b0;
    logic [31:0] load_a = '0;
    rsp_t mon_got, mon_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            mon_got = '{id: rsp_id, res: rsp_result, ovf: rsp_overflow, zero: rsp_zero};
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rsp_unexpected: actual 0x%0h required none", mon_got);
            end else begin
                mon_exp = sb.pop_front();
                check("rsp", 64'(mon_got), 64'(mon_exp));
            end
        end
        if (!$onehot0(req_ready) || ((req_ready & ~req_valid) != 0) || (rst && req_ready != 0))
            bad_ready++;
    end

    task automatic step();
        logic [NR-1:0] acc;
        @(negedge clk);
        acc = rst ? '0 : (req_valid & req_ready);
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                got_ids.push_back(i);
                acc_cyc = cyc;
            end
        end
        if (mul_load) begin
            load_cyc = cyc;
            load_a   = mul_a;
            load_cnt++;
        end
        if (mul_enable) en_cnt++;
        if (rsp_valid && !rsp_prev) begin
            rise_cyc  = cyc;
            rise_seen = 1'b1;
        end
        rsp_prev = rsp_valid;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
    endtask

    task automatic set_op(input int r, input logic [31:0] a, input logic [31:0] b);
        req_a[r*W +: W] = a;
        req_b[r*W +: W] = b;
    endtask

    task automatic push_exp(input int id, input logic [31:0] res, input logic ovf, input logic zero);
        rsp_t e;
        e.id = 2'(id); e.res = res; e.ovf = ovf; e.zero = zero;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((req_valid != 0 || sb.size() != 0 || rsp_valid) && n < 300) begin
            step();
            n++;
        end
        check(name, 64'(n >= 300), 64'(0));
    endtask

    task automatic wait_rise(input string name);
        int n = 0;
        while (!rise_seen && n < 50) begin
            step();
            n++;
        end
        check(name, 64'(rise_seen), 64'(1));
    endtask

    function automatic logic [63:0] order_code();
        logic [63:0] c = '0;
        foreach (got_ids[i]) c = (c << 4) | 64'(got_ids[i]);
        return c;
    endfunction

    task automatic load_all_four();
        set_op(0, 32'h40000000, 32'h40400000);
        set_op(1, 32'h3F800000, 32'h41200000);
        set_op(2, 32'h40800000, 32'h40800000);
        set_op(3, 32'h7F000000, 32'h7F000000);
        push_exp(0, 32'h40C00000, 1'b0, 1'b0);
        push_exp(1, 32'h41200000, 1'b0, 1'b0);
        push_exp(2, 32'h41800000, 1'b0, 1'b0);
        push_exp(3, 32'h7F800000, 1'b1, 1'b0);
        got_ids.delete();
        req_valid = '1;
    endtask

    initial begin
        int bad_stable, bad_rdy;
        logic [35:0] snap;

        // Reset with requests pending: nothing may leak out.
        set_op(0, 32'h3FC00000, 32'h40000000);
        req_valid = '1;
        repeat (3) step();
        check("reset_req_ready", 64'(req_ready), 64'(0));
        check("reset_ctrl", 64'({rsp_valid, mul_enable, mul_load}), 64'(0));
        check("reset_mul_ops", {mul_a, mul_b}, 64'(0));
        check("reset_rsp", 64'({rsp_id, rsp_result, rsp_overflow, rsp_zero}), 64'(0));
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        step();

        rsp_ready = 1'b1;
        load_all_four();
        drain("drain_round1");
        check("grant_order_round1", order_code(), 64'h0123);
        load_all_four();
        drain("drain_round2");
        check("grant_order_round2", order_code(), 64'h0123);

        // Single operation latency and strobe timing.
        set_op(0, 32'h3FC00000, 32'h40000000);
        push_exp(0, 32'h40400000, 1'b0, 1'b0);
        rise_seen = 1'b0;
        req_valid = 4'b0001;
        wait_rise("single_rsp_timeout");
        check("single_latency", 64'(rise_cyc - acc_cyc), 64'(4));
        check("single_load_cycle", 64'(load_cyc - acc_cyc), 64'(1));
        check("single_load_a", 64'(load_a), 64'h3FC00000);
        drain("drain_single");

        // Move rr_ptr to 2, then 1011 must grant 3, 0, 1.
        set_op(1, 32'h3F800000, 32'h41200000);
        push_exp(1, 32'h41200000, 1'b0, 1'b0);
        req_valid = 4'b0010;
        drain("drain_ptr2");
        set_op(0, 32'h40000000, 32'h40400000);
        set_op(3, 32'h7F000000, 32'h7F000000);
        push_exp(3, 32'h7F800000, 1'b1, 1'b0);
        push_exp(0, 32'h40C00000, 1'b0, 1'b0);
        push_exp(1, 32'h41200000, 1'b0, 1'b0);
        got_ids.delete();
        req_valid = 4'b1011;
        drain("drain_fair");
        check("fair_order", order_code(), 64'h0301);

        // Back-pressure: response held for 10 cycles, no new issue.
        rsp_ready = 1'b0;
        set_op(2, 32'h40800000, 32'h40800000);
        push_exp(2, 32'h41800000, 1'b0, 1'b0);
        rise_seen = 1'b0;
        req_valid = 4'b0100;
        wait_rise("bp_rsp_timeout");
        snap = {rsp_id, rsp_result, rsp_overflow, rsp_zero};
        set_op(0, 32'h3FC00000, 32'h40000000);
        push_exp(0, 32'h40400000, 1'b0, 1'b0);
        req_valid[0] = 1'b1;
        load_cnt = 0;
        bad_stable = 0;
        bad_rdy = 0;
        repeat (10) begin
            step();
            if (!rsp_valid || {rsp_id, rsp_result, rsp_overflow, rsp_zero} != snap) bad_stable++;
            if (req_ready != 0) bad_rdy++;
        end
        check("bp_stable", 64'(bad_stable), 64'(0));
        check("bp_req_ready", 64'(bad_rdy), 64'(0));
        check("bp_no_load", 64'(load_cnt), 64'(0));
        rsp_ready = 1'b1;
        drain("drain_bp");

        // Reset during WAIT discards the transaction and rewinds rr_ptr.
        set_op(1, 32'h40000000, 32'h40400000);
        load_cnt = 0;
        req_valid = 4'b0010;
        for (int n = 0; n < 20 && load_cnt == 0; n++) step();
        check("rst_load_seen", 64'(load_cnt), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_ctrl", 64'({req_ready, rsp_valid, mul_enable, mul_load}), 64'(0));
        check("rst_async_mul_a", 64'(mul_a), 64'(0));
        check("rst_async_rsp", 64'({rsp_id, rsp_result, rsp_overflow, rsp_zero}), 64'(0));
        repeat (2) step();
        @(negedge clk);
        rst = 1'b0;
        rise_seen = 1'b0;
        rsp_prev = 1'b0;
        repeat (8) step();
        check("rst_no_rsp", 64'(rise_seen), 64'(0));
        load_all_four();
        drain("drain_after_rst");
        check("rst_grant_order", order_code(), 64'h0123);

        // Zero operand.
        set_op(3, 32'h00000000, 32'h40000000);
        push_exp(3, 32'h00000000, 1'b0, 1'b1);
        en_cnt = 0;
        load_cnt = 0;
        rise_seen = 1'b0;
        req_valid = 4'b1000;
        wait_rise("zero_rsp_timeout");
`ifdef FP_MUL_ZERO_BYPASS_EN
        check("zero_latency", 64'(rise_cyc - acc_cyc), 64'(1));
        check("zero_no_enable", 64'(en_cnt), 64'(0));
`else
        check("zero_latency", 64'(rise_cyc - acc_cyc), 64'(4));
        check("zero_issue_pulse", 64'(load_cnt), 64'(1));
`endif
        drain("drain_zero");

        check("req_ready_legal", 64'(bad_ready), 64'(0));
        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
